dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Data-cache controller that sits between the CPU load/store port, the 2-way `dcache_sram` array and the 256-bit main-memory port. It resolves hits in the same cycle and merges write data into the 32-byte line. On a miss it stalls the CPU, writes back a dirty victim, fetches the line from memory, refills the array, and then replays the access as a hit.

## Interface
Parameters:
- none. Geometry is fixed: 32-bit byte address = tag[31:9] (23 b), index[8:5] (4 b), word[4:2], byte[1:0].

Ports:
- clk_i  in  1  clock, all state updates on posedge
- rst_i  in  1  synchronous, active-high reset
- cpu_req_i  in  1  CPU access request; held stable, with address and data, while cpu_stall_o=1
- cpu_we_i  in  1  1=store, 0=load
- cpu_addr_i  in  32  byte address
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data, valid when cpu_req_i=1 and cpu_stall_o=0
- cpu_stall_o  out  1  1 = access not yet complete
- sram_addr_o  out  4  set index, always cpu_addr_i[8:5]
- sram_tag_o  out  25  {valid, dirty, tag[22:0]}
- sram_data_o  out  256  line to write
- sram_enable_o  out  1  array access enable
- sram_write_o  out  1  array write strobe
- sram_tag_i  in  25  tag of the hit way, or of the LRU victim way on a miss
- sram_data_i  in  256  line of the hit way, or of the victim way
- sram_hit_i  in  1  combinational hit
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = line write-back, 0 = line fetch
- mem_addr_o  out  32  line address, low 5 bits 0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  fetched line, valid when mem_ack_i=1
- mem_ack_i  in  1  one-cycle completion pulse

## Operation
- State machine states: IDLE, MISS, WRITEBACK, ALLOCATE, REFILL. Reset enters IDLE.
- sram_enable_o = cpu_req_i in IDLE and MISS; it is 1 in REFILL.
- **IDLE, read hit:**
  - cpu_data_o = sram_data_i[32·word +: 32].
  - cpu_stall_o=0. The SRAM is not written.
- **IDLE, write hit:**
  - sram_write_o=1.
  - sram_data_o = sram_data_i with word slot replaced by cpu_data_i.
  - sram_tag_o = {1,1,tag}.
  - cpu_stall_o=0.
- **IDLE, miss** (cpu_req_i=1, sram_hit_i=0):
  - cpu_stall_o=1.
  - Next state is MISS.
- **MISS** (one cycle):
  - Latch victim_line=sram_data_i.
  - Latch victim_addr={sram_tag_i[22:0], index, 5'b0}.
  - If sram_tag_i[24] and sram_tag_i[23] are both 1, go to WRITEBACK; otherwise go to ALLOCATE.
- **WRITEBACK:**
  - mem_enable_o=1, mem_write_o=1, mem_addr_o=victim_addr, mem_data_o=victim_line.
  - On mem_ack_i, go to ALLOCATE.
- **ALLOCATE:**
  - mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu_addr_i[31:5], 5'b0}.
  - On mem_ack_i, latch mem_data_i into fill_line and go to REFILL.
- **REFILL** (one cycle):
  - sram_write_o=1, sram_data_o=fill_line, sram_tag_o={1,0,tag}.
  - The SRAM places the line in its LRU way.
  - Next state is IDLE, where the access replays as a hit (a store marks the line dirty then).
- cpu_stall_o = cpu_req_i & ~(state==IDLE & sram_hit_i).
- In all states other than those above, mem_enable_o=0, mem_write_o=0 and sram_write_o=0.

## Timing
- Reset values: state=IDLE, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, sram_write_o=0, cpu_data_o=0 when no request, victim and fill registers=0.
- Hit latency is 0 cycles: the access completes in the cycle it is presented.
- Clean miss latency is 1 (MISS) + A (ALLOCATE, until the ack) + 1 (REFILL) + 1 (IDLE hit) cycles.
- Dirty miss latency adds W WRITEBACK cycles.
- Memory handshake:
  - mem_enable_o and mem_addr_o/mem_data_o are held stable from request assertion until the cycle mem_ack_i=1.
  - mem_enable_o drops, or switches to the next request, on the following edge.
  - An ack arriving in the same cycle the request is first asserted is legal.
- mem_ack_i is ignored in IDLE, MISS and REFILL.
- cpu_req_i dropping mid-miss does not abort the miss. The controller completes the sequence through REFILL, then idles.
- rst_i asserted in any state:
  - Next edge returns to IDLE.
  - mem_enable_o=0 and sram_write_o=0.
  - Any in-flight memory transaction is abandoned.

## Test plan
- **Read hit:** preload set 3, way 0 with tag 0x1, word2=0xDEADBEEF, then load 0x0000_0268 -> cpu_data_o=0xDEADBEEF and cpu_stall_o=0 in the same cycle, no memory request.
- **Write hit:** store 0x12345678 to 0x0000_026C -> SRAM writes the line with word3 replaced and tag {1,1,0x1}, cpu_stall_o=0, no memory request.
- **Clean read miss:** load 0x0000_0400 on an empty cache, memory acks after 5 cycles with line word0=0xA5A5A5A5:
  - mem read at 0x0000_0400.
  - SRAM refill with tag {1,0,0x2}.
  - cpu_data_o=0xA5A5A5A5 with stall released 8 cycles after the request.
- **Dirty miss:** fill both ways of set 0 with dirty lines, then access a third tag -> one mem write of the LRU victim at its original address with the exact line, then one mem read, then refill, then the access completes.
- **Store miss:** store 0xCAFEF00D to a missing address -> fetch and refill clean, then the replayed hit writes the merged line with dirty=1; a subsequent load returns 0xCAFEF00D.
- **Reset mid-miss:** assert rst_i during ALLOCATE -> mem_enable_o=0 next cycle, state IDLE, cpu_stall_o follows cpu_req_i and the hit result.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Data-cache controller: same-cycle hit resolution with store merge, and a
// write-back / allocate / refill miss sequence against a 256-bit memory port.
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic [3:0]   sram_addr_o,
    output logic [24:0]  sram_tag_o,
    output logic [255:0] sram_data_o,
    output logic         sram_enable_o,
    output logic         sram_write_o,
    input  logic [24:0]  sram_tag_i,
    input  logic [255:0] sram_data_i,
    input  logic         sram_hit_i,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [2:0] {StIdle, StMiss, StWriteback, StAllocate, StRefill} state_e;

    state_e         state_q, state_d;
    logic [255:0]   victim_line_q, victim_line_d;
    logic [31:0]    victim_addr_q, victim_addr_d;
    logic [255:0]   fill_line_q, fill_line_d;
    logic [255:0]   merged_line;

    logic [22:0]    tag;
    logic [3:0]     index;
    logic [2:0]     word;
    logic           unused_byte_bits;

    assign tag              = cpu_addr_i[31:9];
    assign index            = cpu_addr_i[8:5];
    assign word             = cpu_addr_i[4:2];
    assign unused_byte_bits = ^cpu_addr_i[1:0];

    assign sram_addr_o = index;
    assign cpu_data_o  = cpu_req_i ? sram_data_i[{word, 5'b00000} +: 32] : 32'h0;
    assign cpu_stall_o = cpu_req_i & ~((state_q == StIdle) & sram_hit_i);

    // Store data merged into the selected word slot of the hit line
    always_comb begin
        merged_line = sram_data_i;
        merged_line[{word, 5'b00000} +: 32] = cpu_data_i;
    end

    // Tag/status to write; kept independent of the array outputs so the
    // array's tag compare never loops back through this controller.
    always_comb begin
        sram_tag_o = {2'b00, tag};
        if (state_q == StRefill) begin
            sram_tag_o = {2'b10, tag};
        end else if (state_q == StIdle && cpu_we_i) begin
            sram_tag_o = {2'b11, tag};
        end
    end

    // Next-state, latch enables and array/memory strobes
    always_comb begin
        state_d       = state_q;
        victim_line_d = victim_line_q;
        victim_addr_d = victim_addr_q;
        fill_line_d   = fill_line_q;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_data_o   = '0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        unique case (state_q)
            StIdle: begin
                sram_enable_o = cpu_req_i;
                if (cpu_req_i) begin
                    if (sram_hit_i) begin
                        if (cpu_we_i) begin
                            sram_write_o = 1'b1;
                            sram_data_o  = merged_line;
                        end
                    end else begin
                        state_d = StMiss;
                    end
                end
            end
            StMiss: begin
                sram_enable_o = cpu_req_i;
                victim_line_d = sram_data_i;
                victim_addr_d = {sram_tag_i[22:0], index, 5'b00000};
                state_d       = (sram_tag_i[24] && sram_tag_i[23]) ? StWriteback : StAllocate;
            end
            StWriteback: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = victim_addr_q;
                mem_data_o   = victim_line_q;
                if (mem_ack_i) begin
                    state_d = StAllocate;
                end
            end
            StAllocate: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {cpu_addr_i[31:5], 5'b00000};
                if (mem_ack_i) begin
                    fill_line_d = mem_data_i;
                    state_d     = StRefill;
                end
            end
            StRefill: begin
                sram_enable_o = 1'b1;
                sram_write_o  = 1'b1;
                sram_data_o   = fill_line_q;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Reset abandons any in-flight transaction and blocks array writes at once
        if (rst_i) begin
            sram_write_o = 1'b0;
            mem_enable_o = 1'b0;
            mem_write_o  = 1'b0;
            mem_addr_o   = '0;
            mem_data_o   = '0;
        end
    end

    // State and miss-bookkeeping registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            victim_line_q <= '0;
            victim_addr_q <= '0;
            fill_line_q   <= '0;
        end else begin
            state_q       <= state_d;
            victim_line_q <= victim_line_d;
            victim_addr_q <= victim_addr_d;
            fill_line_q   <= fill_line_d;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl with a 2-way LRU array model and a
// latency-programmable line memory.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_we_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic         sram_enable_o, sram_write_o, sram_hit_i;
    logic         mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pattern(input logic [31:0] s);
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[32*i +: 32] = s + 32'(i);
        return p;
    endfunction

    function automatic logic [255:0] put_word(input logic [255:0] l, input int w,
                                              input logic [31:0] v);
        logic [255:0] r;
        r = l;
        r[32*w +: 32] = v;
        return r;
    endfunction

    // ---------------- 2-way array model ----------------
    logic         v_a [2][16];
    logic         d_a [2][16];
    logic [22:0]  t_a [2][16];
    logic [255:0] l_a [2][16];
    logic         lru [16];
    logic         hit_way, sel;
    logic         sram_clr, pl_en;
    logic [3:0]   pl_set;
    logic [22:0]  pl_tag;
    logic [255:0] pl_line;

    always_comb begin
        hit_way    = 1'b0;
        sram_hit_i = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (v_a[w][sram_addr_o] && t_a[w][sram_addr_o] == sram_tag_o[22:0]) begin
                sram_hit_i = 1'b1;
                hit_way    = w[0];
            end
        end
        sel         = sram_hit_i ? hit_way : lru[sram_addr_o];
        sram_tag_i  = {v_a[sel][sram_addr_o], d_a[sel][sram_addr_o], t_a[sel][sram_addr_o]};
        sram_data_i = l_a[sel][sram_addr_o];
    end

    always @(posedge clk) begin
        if (sram_clr) begin
            for (int w = 0; w < 2; w++)
                for (int s = 0; s < 16; s++) begin
                    v_a[w][s] <= 1'b0; d_a[w][s] <= 1'b0;
                    t_a[w][s] <= '0;   l_a[w][s] <= '0;
                end
            for (int s = 0; s < 16; s++) lru[s] <= 1'b0;
        end else if (pl_en) begin
            v_a[0][pl_set] <= 1'b1; d_a[0][pl_set] <= 1'b0;
            t_a[0][pl_set] <= pl_tag; l_a[0][pl_set] <= pl_line;
        end else if (sram_enable_o) begin
            if (sram_write_o) begin
                v_a[sel][sram_addr_o] <= sram_tag_o[24];
                d_a[sel][sram_addr_o] <= sram_tag_o[23];
                t_a[sel][sram_addr_o] <= sram_tag_o[22:0];
                l_a[sel][sram_addr_o] <= sram_data_o;
            end
            if (sram_hit_i || sram_write_o) lru[sram_addr_o] <= ~sel;
        end
    end

    // ---------------- memory model ----------------
    logic [255:0] mem [logic [31:0]];
    int mem_lat = 1;

    initial begin
        int cnt;
        cnt        = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack_i = 1'b0;
            if (mem_enable_o) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : '0;
                    cnt        = 0;
                end
            end else begin
                cnt = 0;
            end
            @(negedge clk);
            if (!rst_i && mem_enable_o && mem_write_o && mem_ack_i) mem[mem_addr_o] = mem_data_o;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {logic wr; logic [31:0] addr; logic [255:0] data;} mem_txn_t;
    typedef struct packed {logic [24:0] tag; logic [255:0] data;} sram_txn_t;
    mem_txn_t    exp_mem[$];
    sram_txn_t   exp_sram[$];
    logic [31:0] exp_load[$];

    initial begin
        mem_txn_t  m;
        sram_txn_t s;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (cpu_req_i && !cpu_we_i && !cpu_stall_o) begin
                    if (exp_load.size() == 0) check("load_unexpected", 256'(cpu_addr_i), 256'h0);
                    else check("load_data", 256'(cpu_data_o), 256'(exp_load.pop_front()));
                end
                if (mem_enable_o && mem_ack_i) begin
                    if (exp_mem.size() == 0) begin
                        check("mem_unexpected", 256'(mem_addr_o), 256'h0);
                    end else begin
                        m = exp_mem.pop_front();
                        check("mem_write_flag", 256'(mem_write_o), 256'(m.wr));
                        check("mem_addr", 256'(mem_addr_o), 256'(m.addr));
                        if (m.wr) check("mem_wb_data", mem_data_o, m.data);
                    end
                end
                if (sram_enable_o && sram_write_o) begin
                    if (exp_sram.size() == 0) begin
                        check("sram_unexpected", 256'(sram_tag_o), 256'h0);
                    end else begin
                        s = exp_sram.pop_front();
                        check("sram_tag", 256'(sram_tag_o), 256'(s.tag));
                        check("sram_data", sram_data_o, s.data);
                    end
                end
            end
        end
    end

    // Present one access and hold it until the stall is released
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                             output int cycles);
        cpu_req_i  = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = data;
        cycles     = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!cpu_stall_o) begin
                cycles = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
        if (cycles < 0) check("access_timeout", 256'(addr), 256'h0);
    endtask

    // ---------------- directed stimulus ----------------
    logic [255:0] l3, la, la2, l6, l8, lx, lc;
    int cyc;

    initial begin
        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        sram_clr = 1'b1; pl_en = 1'b0; pl_set = '0; pl_tag = '0; pl_line = '0;
        l3  = put_word(pattern(32'h3000_0000), 2, 32'hDEAD_BEEF);
        la  = pattern(32'hA5A5_A5A5);
        l6  = pattern(32'h6000_0000);
        l8  = pattern(32'h8000_0000);
        lx  = pattern(32'hA000_0000);
        lc  = pattern(32'hC000_0000);
        mem[32'h0000_0400] = la;
        mem[32'h0000_0600] = l6;
        mem[32'h0000_0800] = l8;
        mem[32'h0000_0A20] = lx;
        mem[32'h0000_0C40] = lc;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_enable", 256'(mem_enable_o), 256'h0);
        check("rst_mem_write", 256'(mem_write_o), 256'h0);
        check("rst_mem_addr", 256'(mem_addr_o), 256'h0);
        check("rst_mem_data", mem_data_o, 256'h0);
        check("rst_sram_write", 256'(sram_write_o), 256'h0);
        check("rst_cpu_data", 256'(cpu_data_o), 256'h0);
        check("rst_stall", 256'(cpu_stall_o), 256'h0);
        @(posedge clk); #1;
        sram_clr = 1'b0; pl_en = 1'b1; pl_set = 4'd3; pl_tag = 23'h1; pl_line = l3;
        @(posedge clk); #1;
        pl_en = 1'b0; rst_i = 1'b0;

        // Read hit
        exp_load.push_back(32'hDEAD_BEEF);
        do_access(1'b0, 32'h0000_0268, '0, cyc);
        check("read_hit_latency", 256'(cyc), 256'd0);

        // Write hit
        exp_sram.push_back({2'b11, 23'h1, put_word(l3, 3, 32'h1234_5678)});
        do_access(1'b1, 32'h0000_026C, 32'h1234_5678, cyc);
        check("write_hit_latency", 256'(cyc), 256'd0);

        // Clean read miss, ack in the fifth ALLOCATE cycle
        mem_lat = 5;
        exp_mem.push_back({1'b0, 32'h0000_0400, 256'h0});
        exp_sram.push_back({2'b10, 23'h2, la});
        exp_load.push_back(32'hA5A5_A5A5);
        do_access(1'b0, 32'h0000_0400, '0, cyc);
        check("clean_miss_latency", 256'(cyc), 256'd8);

        // Make both ways of set 0 dirty
        la2 = put_word(la, 0, 32'h1111_1111);
        exp_sram.push_back({2'b11, 23'h2, la2});
        do_access(1'b1, 32'h0000_0400, 32'h1111_1111, cyc);
        mem_lat = 2;
        exp_mem.push_back({1'b0, 32'h0000_0600, 256'h0});
        exp_sram.push_back({2'b10, 23'h3, l6});
        exp_sram.push_back({2'b11, 23'h3, put_word(l6, 0, 32'h2222_2222)});
        do_access(1'b1, 32'h0000_0600, 32'h2222_2222, cyc);
        check("store_miss_latency_lat2", 256'(cyc), 256'd5);

        // Dirty miss: LRU victim is tag 2 in way 0
        mem_lat = 3;
        exp_mem.push_back({1'b1, 32'h0000_0400, la2});
        exp_mem.push_back({1'b0, 32'h0000_0800, 256'h0});
        exp_sram.push_back({2'b10, 23'h4, l8});
        exp_load.push_back(32'h8000_0000);
        do_access(1'b0, 32'h0000_0800, '0, cyc);
        check("dirty_miss_latency", 256'(cyc), 256'd9);
        check("wb_line_in_memory", mem[32'h0000_0400], la2);

        // Store miss with an ack in the first request cycle
        mem_lat = 1;
        exp_mem.push_back({1'b0, 32'h0000_0A20, 256'h0});
        exp_sram.push_back({2'b10, 23'h5, lx});
        exp_sram.push_back({2'b11, 23'h5, put_word(lx, 1, 32'hCAFE_F00D)});
        do_access(1'b1, 32'h0000_0A24, 32'hCAFE_F00D, cyc);
        check("store_miss_latency", 256'(cyc), 256'd4);
        exp_load.push_back(32'hCAFE_F00D);
        do_access(1'b0, 32'h0000_0A24, '0, cyc);
        check("store_miss_reload_latency", 256'(cyc), 256'd0);

        // Reset while in ALLOCATE
        mem_lat = 10;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0C40;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_enable_o) break;
            @(posedge clk); #1;
        end
        check("alloc_enable", 256'(mem_enable_o), 256'h1);
        check("alloc_addr", 256'(mem_addr_o), 256'h0000_0C40);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0; cpu_req_i = 1'b0;
        @(negedge clk);
        check("post_rst_mem_enable", 256'(mem_enable_o), 256'h0);
        check("post_rst_sram_write", 256'(sram_write_o), 256'h0);
        check("post_rst_stall_idle", 256'(cpu_stall_o), 256'h0);
        @(posedge clk); #1;
        exp_load.push_back(32'hDEAD_BEEF);
        do_access(1'b0, 32'h0000_0268, '0, cyc);
        check("post_rst_hit_latency", 256'(cyc), 256'd0);

        // Request dropped after one cycle: the miss still runs to REFILL
        mem_lat = 2;
        exp_mem.push_back({1'b0, 32'h0000_0C40, 256'h0});
        exp_sram.push_back({2'b10, 23'h6, lc});
        cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_0C40;
        @(negedge clk);
        check("miss_stall", 256'(cpu_stall_o), 256'h1);
        @(posedge clk); #1;
        cpu_req_i = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("refill_after_drop", {255'h0, v_a[0][2]}, 256'h1);
        check("exp_mem_drained", 256'(exp_mem.size()), 256'h0);
        check("exp_sram_drained", 256'(exp_sram.size()), 256'h0);
        check("exp_load_drained", 256'(exp_load.size()), 256'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
